inst_fetch_ctrl: RTL and testbench

Sequences the fetch stage: owns the PC, issues word reads to INST_MEM, buffers returned instructions, and hands them to decode over a valid/ready handshake. Handles taken-branch/jump redirects, including flushing buffered instructions and discarding a stale in-flight memory response. Sits between INST_MEM and the decode stage.

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch_fifo.sv | 54 +++++
 rtl/inst_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// The S_IDLE_HALT state exists only when MISALIGN_TRAP_EN is defined.
package inst_fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_INC       = 4;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT      = 3'd2,
    S_DROP      = 3'd3,
    S_FULL      = 3'd4
`ifdef MISALIGN_TRAP_EN
    ,
    S_IDLE_HALT = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} entries; flush empties it in one edge.
// Pushes into a full FIFO are ignored unless a pop frees the slot in the same cycle.
module inst_fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, sequences INST_MEM reads, buffers and redirects.
// Build option MISALIGN_TRAP_EN: a misaligned redirect target sets a sticky fault and halts fetch.
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            fetch_fault,
  output logic [2:0]      dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [2*XLEN-1:0] head;
  logic              redirect;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   target;

`ifdef MISALIGN_TRAP_EN
  logic fault_q;
  logic misaligned;
  assign redirect    = br_taken && (state != S_IDLE) && (state != S_IDLE_HALT);
  assign misaligned  = (br_target[1:0] != 2'b00);
  assign target      = br_target;
  assign fetch_fault = fault_q;
`else
  assign redirect    = br_taken && (state != S_IDLE);
  assign target      = br_target & ~XLEN'(3);
  assign fetch_fault = 1'b0;
`endif

  // Decode handshake: an entry transfers on a cycle with if_valid && if_ready and no
  // br_taken; if_inst/if_pc stay stable while if_valid is high and not accepted.
  assign push       = (state == S_WAIT) && mem_valid && !redirect;
  assign pop        = if_valid && if_ready && !br_taken;
  assign count_next = count + CW'(push) - CW'(pop);

  assign mem_req         = (state == S_REQ);
  assign mem_addr        = mem_req ? pc : '0;
  assign if_valid        = (count != '0);
  assign {if_pc, if_inst} = if_valid ? head : '0;
  assign dbg_state       = state;

  inst_fetch_fifo #(.W(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({pc, mem_data}),
    .dout  (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else if (redirect) begin
      pc <= target;
      case (state)
        S_REQ:           state <= S_DROP;
        // A response landing on the redirect edge is the stale one: consume it and refetch.
        S_WAIT, S_DROP:  state <= mem_valid ? S_REQ : S_DROP;
        default:         state <= S_REQ;
      endcase
`ifdef MISALIGN_TRAP_EN
      if (misaligned) begin
        state   <= S_IDLE_HALT;
        fault_q <= 1'b1;
      end
`endif
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ:  state <= S_WAIT;
        S_WAIT: begin
          if (mem_valid) begin
            pc    <= pc + XLEN'(PC_INC);
            state <= (count_next < CW'(FIFO_DEPTH)) ? S_REQ : S_FULL;
          end
        end
        S_FULL: if (pop) state <= S_REQ;
        S_DROP: if (mem_valid) state <= S_REQ;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: cycle table, hand-written redirect/reset sequences,
// and randomized traffic checked by a stream-level model of the fetched instructions.
module tb_inst_fetch_ctrl;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fetch_fault;
  logic [2:0]  dbg_state;

  inst_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .br_taken(br_taken), .br_target(br_target), .fetch_fault(fetch_fault),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0050_0093;
      32'd4:   return 32'h00a0_0113;
      32'd8:   return 32'h0020_81b3;
      32'd12:  return NOP;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- INST_MEM model: one response, mem_lat cycles after the request
  int          mem_lat = 1;
  bit          mem_rand = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = '0;

  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      mem_data  = '0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem_word(resp_addr);
        end
      end
      if (mem_req) begin
        resp_cnt  = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        resp_addr = mem_addr;
      end
    end
  end

  // ---------------- Stream model: requests and accepted instructions follow the PC stream
  logic [31:0] exp_req = RST_PC;
  logic [31:0] exp_pc  = RST_PC;
  int          since_rel = 0;
  int          acc_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_req   = RST_PC;
      exp_pc    = RST_PC;
      since_rel = 0;
    end else begin
      if (mem_req) begin
        check("req_addr", mem_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end else begin
        check("addr_idle", mem_addr, 32'd0);
      end
      if (!if_valid) begin
        check("empty_pc", if_pc, 32'd0);
        check("empty_inst", if_inst, 32'd0);
      end else if (if_ready && !br_taken) begin
        check("acc_pc", if_pc, exp_pc);
        check("acc_inst", if_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        acc_cnt++;
      end
      if (br_taken && since_rel > 0) begin
        exp_req = br_target & ~32'h3;
        exp_pc  = br_target & ~32'h3;
      end
      since_rel++;
    end
  end

  // ---------------- Driver tasks
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset(input int lat);
    @(posedge clk); #2;
    rst_n = 1'b0; br_taken = 1'b0; br_target = '0; if_ready = 1'b0;
    mem_lat = lat; mem_rand = 0;
    #1;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_inst", if_inst, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr, input int budget);
    bit got = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (mem_req) begin got = 1; break; end
      tick();
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s: no request within %0d cycles, expected addr %h", name, budget, addr);
    end else check(name, mem_addr, addr);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc, input int budget);
    bit got = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (if_valid) begin got = 1; break; end
      tick();
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s: no if_valid within %0d cycles, expected pc %h", name, budget, pc);
    end else begin
      check({name, "_pc"}, if_pc, pc);
      check({name, "_inst"}, if_inst, mem_word(pc));
    end
  endtask

  // ---------------- Cycle table
  typedef struct {
    bit          rst;
    int          lat;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_v;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0, last, stall;
    rst_n = 1'b0; if_ready = 1'b0; br_taken = 1'b0; br_target = '0;

    // Straight-line fetch, decode always ready, 1-cycle memory.
    tbl.push_back('{1, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 1, 1, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 1, 1, 32'h4,  1, 32'h0,  32'h0050_0093});
    tbl.push_back('{0, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 1, 1, 32'h8,  1, 32'h4,  32'h00a0_0113});
    tbl.push_back('{0, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 1, 1, 32'hc,  1, 32'h8,  32'h0020_81b3});
    tbl.push_back('{0, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 1, 1, 32'h10, 1, 32'hc,  32'h0000_0013});
    // Decode stalled: two fetches fill the buffer, then one pop releases the next request.
    tbl.push_back('{1, 1, 0, 0, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 0, 1, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 0, 0, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 0, 1, 32'h4,  1, 32'h0,  32'h0050_0093});
    tbl.push_back('{0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h0050_0093});
    tbl.push_back('{0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h0050_0093});
    tbl.push_back('{0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h0050_0093});
    tbl.push_back('{0, 1, 1, 0, 32'h0,  1, 32'h0,  32'h0050_0093});
    tbl.push_back('{0, 1, 1, 1, 32'h8,  1, 32'h4,  32'h00a0_0113});
    tbl.push_back('{0, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0});
    tbl.push_back('{0, 1, 1, 1, 32'hc,  1, 32'h8,  32'h0020_81b3});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(tbl[i].lat);
      else tick();
      if_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_req", i), {31'd0, mem_req}, {31'd0, tbl[i].e_req});
      check($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
      check($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_v});
      check($sformatf("vec%0d_pc", i), if_pc, tbl[i].e_pc);
      check($sformatf("vec%0d_inst", i), if_inst, tbl[i].e_inst);
    end

    // Redirect while the request at 8 is outstanding (3-cycle memory) with pc 4 buffered.
    do_reset(3);
    wait_req("t3_req0", 32'h0, 5);
    wait_req("t3_req4", 32'h4, 10);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("t3_stall", {31'd0, mem_req}, 32'd0);
    end
    tick(); if_ready = 1'b1;
    @(negedge clk);
    check("t3_head", if_pc, 32'h0);
    tick(); if_ready = 1'b0;
    @(negedge clk);
    check("t3_req8_req", {31'd0, mem_req}, 32'd1);
    check("t3_req8_addr", mem_addr, 32'h8);
    tick(); br_taken = 1'b1; br_target = 32'h40;
    @(negedge clk);
    check("t3_prebr_valid", {31'd0, if_valid}, 32'd1);
    tick(); br_taken = 1'b0; if_ready = 1'b1;
    @(negedge clk);
    check("t3_flushed", {31'd0, if_valid}, 32'd0);
    wait_req("t3_req40", 32'h40, 10);
    wait_valid("t3_first", 32'h40, 10);

    // Redirect coincident with the response: no push, no extra drop.
    do_reset(1);
    if_ready = 1'b1;
    wait_req("t4_req0", 32'h0, 5);
    tick(); br_taken = 1'b1; br_target = 32'h80;
    @(negedge clk);
    tick(); br_taken = 1'b0;
    @(negedge clk);
    check("t4_req_now", {31'd0, mem_req}, 32'd1);
    check("t4_addr", mem_addr, 32'h80);
    check("t4_no_push", {31'd0, if_valid}, 32'd0);
    wait_valid("t4_first", 32'h80, 10);

    // Reset mid-wait with a buffered entry; the late response lands while idle.
    do_reset(3);
    wait_req("t5_req0", 32'h0, 5);
    wait_req("t5_req4", 32'h4, 10);
    tick();
    @(negedge clk);
    check("t5_pre_valid", {31'd0, if_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_valid", {31'd0, if_valid}, 32'd0);
    check("t5_async_pc", if_pc, 32'd0);
    check("t5_async_inst", if_inst, 32'd0);
    check("t5_async_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    if_ready = 1'b1;
    wait_req("t5_req_rst", RST_PC, 5);
    wait_valid("t5_first", RST_PC, 10);

    // Misaligned redirect target issued while a request is in flight.
    do_reset(1);
    if_ready = 1'b1;
    wait_req("t6_req0", 32'h0, 5);
    tick();
    tick(); br_taken = 1'b1; br_target = 32'h42;
    @(negedge clk);
    tick(); br_taken = 1'b0;
`ifdef MISALIGN_TRAP_EN
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t6_fault", {31'd0, fetch_fault}, 32'd1);
      check("t6_halt_req", {31'd0, mem_req}, 32'd0);
      check("t6_halt_valid", {31'd0, if_valid}, 32'd0);
      tick();
    end
`else
    @(negedge clk);
    check("t6_fault", {31'd0, fetch_fault}, 32'd0);
    wait_req("t6_req40", 32'h40, 10);
`endif

    // Randomized traffic against the stream model.
    do_reset(1);
    mem_rand = 1;
    acc0 = acc_cnt; last = acc_cnt; stall = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if_ready = ($urandom_range(0, 3) != 0);
      br_taken = (cyc > 2) && ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) br_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else br_target = 32'($urandom_range(0, 1023));
`ifdef MISALIGN_TRAP_EN
      br_target = br_target & ~32'h3;
`endif
      if (acc_cnt != last) begin last = acc_cnt; stall = 0; end
      else stall++;
      if (stall > 80) begin
        n_vec++; n_err++;
        $display("FAIL rand_stall: no accept for %0d cycles, expected steady progress", stall);
        break;
      end
    end
    tick(); br_taken = 1'b0;
    check("rand_progress", {31'd0, (acc_cnt - acc0) >= 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
